pipeline_chain: RTL and testbench

PIPELINE_CHAIN -- requirements
Module: pipeline_chain

---
 rtl/pipeline_chain_pkg.sv | 16 +
 rtl/pipe_stage.sv | 53 +++++
 rtl/pipeline_chain.sv | 170 +++++++++++++++++
 tb/tb_pipeline_chain.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_chain_pkg.sv
// rtl/pipeline_chain_pkg.sv - shared types and default sizes for pipeline_chain
// Purpose : final-stage state encoding and default parameter values.
// Ports   : none (package).
package pipeline_chain_pkg;

   localparam int DEF_WIDTH  = 8;
   localparam int DEF_STAGES = 4;
   localparam int DEF_HOLD_W = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      PRESENT = 2'd2
   } fin_state_e;

endpackage

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - one valid/data register stage that adds a constant on capture
// Purpose : holds one item; captures in_data + ADD when upstream is valid and
//           this stage is free or emptying in the same cycle.
// Ports   : clk, rst_n        clock, async active-low reset
//           in_valid, in_data upstream item
//           out_ready         next stage accepts this cycle
//           out_valid, out_data held item
module pipe_stage #(
   parameter int WIDTH = 8,
   parameter int ADD   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   localparam logic [WIDTH-1:0] ADD_C = WIDTH'(ADD);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             capture;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      // Free, or releasing this cycle: capture and release together is lossless.
      capture = in_valid && (!valid_q || out_ready);
      if (capture) begin
         valid_d = 1'b1;
         data_d  = in_data + ADD_C;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;

endmodule

// File: rtl/pipeline_chain.sv
// rtl/pipeline_chain.sv - valid/ready register chain with an add per stage and a holding final stage
// Purpose : STAGES-1 generic stages (pipe_stage) followed by a final stage FSM
//           (IDLE/HOLD/PRESENT) that waits hold_cfg cycles before presenting.
//           Optional macro PIPELINE_CHAIN_STATS_EN adds saturating stall and
//           transfer counters.
// Ports   : fast_clk, rst_n          clock, async active-low reset
//           in_valid/in_ready/in_data upstream handshake
//           out_valid/out_ready/out_data downstream handshake
//           hold_cfg                  extra wait cycles of the final stage
//           occupancy                 number of stages holding an item
//           stall_cycles, xfer_count  (PIPELINE_CHAIN_STATS_EN only)
module pipeline_chain
   import pipeline_chain_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES,
   parameter int HOLD_W = DEF_HOLD_W
) (
   input  logic                       fast_clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   input  logic [HOLD_W-1:0]          hold_cfg,
`ifdef PIPELINE_CHAIN_STATS_EN
   output logic [31:0]                stall_cycles,
   output logic [31:0]                xfer_count,
`endif
   output logic [$clog2(STAGES+1)-1:0] occupancy
);

   localparam int               OCC_W    = $clog2(STAGES+1);
   localparam logic [WIDTH-1:0] FIN_ADD  = WIDTH'(STAGES);

   logic                rst_done_q, rst_done_d;
   logic [STAGES-2:0]   vld;
   logic [STAGES-1:0]   rdy;
   logic [WIDTH-1:0]    dat [STAGES-1];

   fin_state_e          state_q, state_d;
   logic [HOLD_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]    fdata_q, fdata_d;
   logic                fin_ready, fin_capture;
   logic [OCC_W-1:0]    occ_q, occ_d;
   logic                in_xfer, out_xfer;

   genvar gi;
   generate
      for (gi = 0; gi < STAGES-1; gi++) begin : g_stage
         if (gi == 0) begin : g_first
            pipe_stage #(.WIDTH(WIDTH), .ADD(1)) u_stage (
               .clk       (fast_clk),
               .rst_n     (rst_n),
               .in_valid  (in_valid && rst_done_q),
               .in_data   (in_data),
               .out_ready (rdy[1]),
               .out_valid (vld[0]),
               .out_data  (dat[0])
            );
         end else begin : g_mid
            pipe_stage #(.WIDTH(WIDTH), .ADD(gi+1)) u_stage (
               .clk       (fast_clk),
               .rst_n     (rst_n),
               .in_valid  (vld[gi-1]),
               .in_data   (dat[gi-1]),
               .out_ready (rdy[gi+1]),
               .out_valid (vld[gi]),
               .out_data  (dat[gi])
            );
         end
      end
   endgenerate

   // Ready ripples back from the final stage in one combinational pass.
   always_comb begin
      logic r;
      rdy             = '0;
      r               = fin_ready;
      rdy[STAGES-1]   = fin_ready;
      for (int k = STAGES-2; k >= 0; k--) begin
         r      = !vld[k] || r;
         rdy[k] = r;
      end
   end

   // rst_done_q keeps in_ready low until the first edge after reset release.
   assign in_ready  = rdy[0] && rst_done_q;
   assign out_valid = (state_q == PRESENT);
   assign out_data  = fdata_q;
   assign occupancy = occ_q;

   assign fin_ready   = (state_q == IDLE) || ((state_q == PRESENT) && out_ready);
   assign fin_capture = vld[STAGES-2] && fin_ready;
   assign in_xfer     = in_valid && in_ready;
   assign out_xfer    = out_valid && out_ready;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      fdata_d    = fdata_q;
      rst_done_d = 1'b1;
      occ_d      = occ_q + OCC_W'(in_xfer) - OCC_W'(out_xfer);
      case (state_q)
         HOLD: begin
            // Count sampled at capture; PRESENT on the edge it would reach zero.
            if (cnt_q <= HOLD_W'(1)) begin
               state_d = PRESENT;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - HOLD_W'(1);
            end
         end
         PRESENT: if (out_ready) state_d = IDLE;
         default: ;
      endcase
      if (fin_capture) begin
         fdata_d = dat[STAGES-2] + FIN_ADD;
         if (hold_cfg != '0) begin
            state_d = HOLD;
            cnt_d   = hold_cfg;
         end else begin
            state_d = PRESENT;
         end
      end
   end

   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         fdata_q    <= '0;
         occ_q      <= '0;
         rst_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         fdata_q    <= fdata_d;
         occ_q      <= occ_d;
         rst_done_q <= rst_done_d;
      end
   end

`ifdef PIPELINE_CHAIN_STATS_EN
   logic [31:0] stall_q, stall_d, xfer_q, xfer_d;

   always_comb begin
      stall_d = stall_q;
      xfer_d  = xfer_q;
      if (out_valid && !out_ready && (stall_q != '1)) stall_d = stall_q + 32'd1;
      if (out_xfer && (xfer_q != '1))                 xfer_d  = xfer_q + 32'd1;
   end

   always_ff @(posedge fast_clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_q <= '0;
         xfer_q  <= '0;
      end else begin
         stall_q <= stall_d;
         xfer_q  <= xfer_d;
      end
   end

   assign stall_cycles = stall_q;
   assign xfer_count   = xfer_q;
`endif

endmodule

// File: tb/tb_pipeline_chain.sv
// tb/tb_pipeline_chain.sv - directed self-checking bench for pipeline_chain (WIDTH=8, STAGES=4)
module tb_pipeline_chain;

   logic       fast_clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic [3:0] hold_cfg;
   logic [2:0] occupancy;
`ifdef PIPELINE_CHAIN_STATS_EN
   logic [31:0] stall_cycles;
   logic [31:0] xfer_count;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   pipeline_chain #(.WIDTH(8), .STAGES(4), .HOLD_W(4)) dut (
      .fast_clk  (fast_clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .hold_cfg  (hold_cfg),
`ifdef PIPELINE_CHAIN_STATS_EN
      .stall_cycles (stall_cycles),
      .xfer_count   (xfer_count),
`endif
      .occupancy (occupancy)
   );

   initial forever #5 fast_clk = ~fast_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Offer one item, return edges until out_valid is seen (accept edge = 1).
   task automatic send_time(input logic [7:0] d, input int chg, output int lat, output logic [7:0] od);
      in_valid = 1'b1;
      in_data  = d;
      lat      = 0;
      do begin
         @(posedge fast_clk);
         lat++;
         @(negedge fast_clk);
         in_valid = 1'b0;
         if (lat == chg) hold_cfg = 4'd0;
      end while (!out_valid && lat < 20);
      od = out_data;
   endtask

   initial begin
      int         lat;
      int         n;
      int         k;
      int         seen;
      logic       acc;
      logic [7:0] od;
      logic [7:0] got [8];
      int         cyc [8];

      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; hold_cfg = '0;

      // Reset state
      repeat (2) @(negedge fast_clk);
      check_eq("rst_out_valid", out_valid, 0);
      check_eq("rst_out_data",  out_data,  0);
      check_eq("rst_occupancy", occupancy, 0);
      check_eq("rst_in_ready",  in_ready,  0);
      rst_n = 1'b1;
      #1 check_eq("in_ready_before_edge", in_ready, 0);
      @(negedge fast_clk);
      check_eq("in_ready_after_edge", in_ready, 1);

      // Single item and wrap
      send_time(8'd10, 0, lat, od);
      check_eq("lat_10", lat, 4);
      check_eq("data_10", od, 20);
      send_time(8'd250, 0, lat, od);
      check_eq("lat_250", lat, 4);
      check_eq("data_wrap", od, 4);

      // Back-to-back 1,2,3
      n = 0;
      for (int c = 0; c < 12; c++) begin
         in_valid = (c < 3);
         in_data  = 8'(c + 1);
         @(posedge fast_clk);
         @(negedge fast_clk);
         if (out_valid && n < 8) begin got[n] = out_data; cyc[n] = c; n++; end
      end
      check_eq("b2b_count", n, 3);
      check_eq("b2b_d0", got[0], 11);
      check_eq("b2b_d1", got[1], 12);
      check_eq("b2b_d2", got[2], 13);
      check_eq("b2b_first_cycle", cyc[0], 3);
      check_eq("b2b_consec1", cyc[1], 4);
      check_eq("b2b_consec2", cyc[2], 5);

      // Backpressure: 5 offered, 4 accepted
      out_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 8; c++) begin
         in_valid = (k < 5);
         in_data  = 8'(20 + k);
         #1 acc = in_valid && in_ready;
         @(posedge fast_clk);
         @(negedge fast_clk);
         if (acc) k++;
      end
      #1;
      check_eq("bp_accepted", k, 4);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_occupancy", occupancy, 4);
      check_eq("bp_out_data", out_data, 30);
      repeat (2) @(negedge fast_clk);
      check_eq("bp_out_data_stable", out_data, 30);
      n = 0;
      for (int c = 0; c < 12; c++) begin
         in_valid  = (k < 5);
         in_data   = 8'(20 + k);
         out_ready = 1'b1;
         #1 acc = in_valid && in_ready;
         if (out_valid && n < 8) begin got[n] = out_data; n++; end
         @(posedge fast_clk);
         @(negedge fast_clk);
         if (acc) k++;
      end
      in_valid = 1'b0;
      check_eq("bp_total_accepted", k, 5);
      check_eq("bp_out_count", n, 5);
      for (int j = 0; j < 5; j++) check_eq($sformatf("bp_out%0d", j), got[j], 32'(30 + j));

      // Hold
      hold_cfg = 4'd3;
      send_time(8'd10, 0, lat, od);
      check_eq("hold3_lat", lat, 7);
      check_eq("hold3_data", od, 20);
      hold_cfg = 4'd3;
      send_time(8'd7, 5, lat, od);
      check_eq("hold3_change_lat", lat, 7);
      check_eq("hold3_change_data", od, 17);
      hold_cfg = 4'd0;

      // Reset with 3 items in flight
      for (int c = 0; c < 3; c++) begin
         in_valid = 1'b1;
         in_data  = 8'(c + 1);
         @(posedge fast_clk);
         @(negedge fast_clk);
      end
      in_valid = 1'b0;
      check_eq("inflight_occupancy", occupancy, 3);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_out_valid", out_valid, 0);
      check_eq("midrst_occupancy", occupancy, 0);
      check_eq("midrst_in_ready", in_ready, 0);
      @(negedge fast_clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge fast_clk);
         if (out_valid) seen++;
      end
      check_eq("no_stale_items", seen, 0);

`ifdef PIPELINE_CHAIN_STATS_EN
      for (int c = 0; c < 14; c++) begin
         in_valid  = (c < 4);
         in_data   = 8'(c);
         out_ready = (c >= 10);
         @(posedge fast_clk);
         @(negedge fast_clk);
      end
      in_valid = 1'b0;
      check_eq("stall_cycles", stall_cycles, 6);
      check_eq("xfer_count", xfer_count, 4);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
